// File: rtl/reg_cmd_sequencer.sv
// reg_cmd_sequencer
// Three-state command sequencer (IDLE -> READ -> WRITE) in front of a 4x8
// dual-port register storage. A command is accepted in IDLE, the storage
// is read in READ (operands latched at the READ edge), and the ALU result
// is written back in WRITE. SWAP uses both storage write ports at once.
//
// Ports
//   CLK, RST                      clock, asynchronous active-high reset
//   cmd_valid / cmd_ready         command handshake (ready only in IDLE)
//   cmd_op, cmd_dst, cmd_src_a,
//   cmd_src_b, cmd_imm            command fields
//   read_address_A/B              storage read addresses (held outside READ)
//   rd_data_A/B                   combinational storage read data
//   write_enable_A/B, write_address_A/B, data_input_A/B
//                                 storage write ports (active only in WRITE)
//   done                          high for the single WRITE cycle
//   flag_c, flag_z                carry/borrow and zero of the last command
module reg_cmd_sequencer (
    input  logic       CLK,
    input  logic       RST,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [1:0] cmd_dst,
    input  logic [1:0] cmd_src_a,
    input  logic [1:0] cmd_src_b,
    input  logic [7:0] cmd_imm,
    output logic [1:0] read_address_A,
    output logic [1:0] read_address_B,
    input  logic [7:0] rd_data_A,
    input  logic [7:0] rd_data_B,
    output logic       write_enable_A,
    output logic       write_enable_B,
    output logic [1:0] write_address_A,
    output logic [1:0] write_address_B,
    output logic [7:0] data_input_A,
    output logic [7:0] data_input_B,
    output logic       done,
    output logic       flag_c,
    output logic       flag_z
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MOV  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_LDI  = 3'd6;
    localparam logic [2:0] OP_SWAP = 3'd7;

    state_t      state_q, state_d;
    logic [2:0]  op_q;
    logic [1:0]  dst_q, src_a_q, src_b_q;
    logic [7:0]  imm_q, opa_q, opb_q;
    logic        flag_c_q, flag_z_q;
    logic        accept_s;
    logic [8:0]  sum_s;
    logic [7:0]  result_s;
    logic        carry_s;

    assign accept_s = cmd_valid && (state_q == ST_IDLE);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: READ and WRITE each last exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  begin
                if (cmd_valid) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Command capture; the source registers double as the held read addresses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_q    <= 3'd0;
            dst_q   <= 2'd0;
            src_a_q <= 2'd0;
            src_b_q <= 2'd0;
            imm_q   <= 8'd0;
        end else if (accept_s) begin
            op_q    <= cmd_op;
            dst_q   <= cmd_dst;
            src_a_q <= cmd_src_a;
            src_b_q <= cmd_src_b;
            imm_q   <= cmd_imm;
        end
    end

    // Operand latch at the READ edge, so dst may alias a source safely.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            opa_q <= 8'd0;
            opb_q <= 8'd0;
        end else if (state_q == ST_READ) begin
            opa_q <= rd_data_A;
            opb_q <= rd_data_B;
        end
    end

    // ALU: result and carry/borrow from the latched operands.
    always_comb begin
        sum_s    = {1'b0, opa_q} + {1'b0, opb_q};
        result_s = 8'd0;
        carry_s  = 1'b0;
        case (op_q)
            OP_MOV:  result_s = opa_q;
            OP_ADD:  begin
                result_s = sum_s[7:0];
                carry_s  = sum_s[8];
            end
            OP_SUB:  begin
                result_s = opa_q - opb_q;
                carry_s  = (opa_q < opb_q);
            end
            OP_AND:  result_s = opa_q & opb_q;
            OP_OR:   result_s = opa_q | opb_q;
            OP_XOR:  result_s = opa_q ^ opb_q;
            OP_LDI:  result_s = imm_q;
            OP_SWAP: result_s = 8'd0;
            default: result_s = 8'd0;
        endcase
    end

    // Flags update at the WRITE edge; SWAP clears carry and keeps zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else if (state_q == ST_WRITE) begin
            flag_c_q <= carry_s;
            if (op_q != OP_SWAP) begin
                flag_z_q <= (result_s == 8'd0);
            end
        end
    end

    // Write ports, decoded straight from the state so RST kills them at once.
    always_comb begin
        write_enable_A  = 1'b0;
        write_enable_B  = 1'b0;
        write_address_A = 2'd0;
        write_address_B = 2'd0;
        data_input_A    = 8'd0;
        data_input_B    = 8'd0;
        if (state_q == ST_WRITE) begin
            if (op_q == OP_SWAP) begin
                write_enable_A  = 1'b1;
                write_address_A = src_a_q;
                data_input_A    = opb_q;
                // Same-address SWAP is a no-op; one port avoids a write collision.
                write_enable_B  = (src_a_q != src_b_q);
                write_address_B = src_b_q;
                data_input_B    = opa_q;
            end else begin
                write_enable_A  = 1'b1;
                write_address_A = dst_q;
                data_input_A    = result_s;
            end
        end else begin
            write_enable_A = 1'b0;
            write_enable_B = 1'b0;
        end
    end

    assign cmd_ready      = (state_q == ST_IDLE);
    assign done           = (state_q == ST_WRITE);
    assign read_address_A = src_a_q;
    assign read_address_B = src_b_q;
    assign flag_c         = flag_c_q;
    assign flag_z         = flag_z_q;

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Directed and random testbench for reg_cmd_sequencer with a behavioural
// 4x8 dual-port storage and an independent reference model.
module tb_reg_cmd_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_dst, cmd_src_a, cmd_src_b;
    logic [7:0] cmd_imm;
    logic [1:0] read_address_A, read_address_B;
    logic [7:0] rd_data_A, rd_data_B;
    logic       write_enable_A, write_enable_B;
    logic [1:0] write_address_A, write_address_B;
    logic [7:0] data_input_A, data_input_B;
    logic       done, flag_c, flag_z;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [4];
    int         wr_count;
    logic       wr_count_clr;

    logic [7:0] ref_mem [4];
    logic       ref_c, ref_z;

    typedef struct packed {
        logic       rd_ready;
        logic       rd_done;
        logic [1:0] ra;
        logic [1:0] rb;
        logic       w_done;
        logic       w_ready;
        logic       we_a;
        logic [1:0] wa;
        logic [7:0] da;
        logic       we_b;
        logic [1:0] wb;
        logic [7:0] db;
        logic       post_done;
    } samp_t;

    samp_t s;

    always #5 CLK = ~CLK;

    reg_cmd_sequencer dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a),
        .cmd_src_b(cmd_src_b), .cmd_imm(cmd_imm),
        .read_address_A(read_address_A), .read_address_B(read_address_B),
        .rd_data_A(rd_data_A), .rd_data_B(rd_data_B),
        .write_enable_A(write_enable_A), .write_enable_B(write_enable_B),
        .write_address_A(write_address_A), .write_address_B(write_address_B),
        .data_input_A(data_input_A), .data_input_B(data_input_B),
        .done(done), .flag_c(flag_c), .flag_z(flag_z)
    );

    assign rd_data_A = mem[read_address_A];
    assign rd_data_B = mem[read_address_B];

    // Behavioural storage with a write counter.
    always @(posedge CLK) begin
        if (write_enable_A) mem[write_address_A] <= data_input_A;
        if (write_enable_B) mem[write_address_B] <= data_input_B;
        if (wr_count_clr) wr_count <= 0;
        else wr_count <= wr_count + (write_enable_A ? 1 : 0) + (write_enable_B ? 1 : 0);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full command, entered and left at posedge+1 in IDLE.
    task automatic run_cmd(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] a,
                           input logic [1:0] b, input logic [7:0] imm, output samp_t o);
        cmd_op = op; cmd_dst = dst; cmd_src_a = a; cmd_src_b = b; cmd_imm = imm;
        cmd_valid = 1'b1;
        @(posedge CLK); #1;
        cmd_valid   = 1'b0;
        o.rd_ready  = cmd_ready;
        o.rd_done   = done;
        o.ra        = read_address_A;
        o.rb        = read_address_B;
        @(posedge CLK); #1;
        o.w_done    = done;
        o.w_ready   = cmd_ready;
        o.we_a      = write_enable_A;
        o.wa        = write_address_A;
        o.da        = data_input_A;
        o.we_b      = write_enable_B;
        o.wb        = write_address_B;
        o.db        = data_input_B;
        @(posedge CLK); #1;
        o.post_done = done;
    endtask

    // Reference model update for one command.
    task automatic ref_apply(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] a,
                             input logic [1:0] b, input logic [7:0] imm);
        logic [7:0] x, y, r;
        x = ref_mem[a];
        y = ref_mem[b];
        r = 8'h00;
        ref_c = 1'b0;
        case (op)
            3'd0: r = x;
            3'd1: begin r = x + y; ref_c = ({1'b0, x} + {1'b0, y}) > 9'd255; end
            3'd2: begin r = x - y; ref_c = (x < y); end
            3'd3: r = x & y;
            3'd4: r = x | y;
            3'd5: r = x ^ y;
            3'd6: r = imm;
            default: r = 8'h00;
        endcase
        if (op == 3'd7) begin
            ref_mem[a] = y;
            ref_mem[b] = x;
        end else begin
            ref_mem[dst] = r;
            ref_z = (r == 8'h00);
        end
    endtask

    task automatic preload;
        samp_t t;
        run_cmd(3'd6, 2'd0, 2'd0, 2'd0, 8'h10, t);
        run_cmd(3'd6, 2'd1, 2'd0, 2'd0, 8'hF5, t);
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_dst = 2'd0; cmd_src_a = 2'd0;
        cmd_src_b = 2'd0; cmd_imm = 8'd0; wr_count_clr = 1'b1;
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        RST = 1'b1;
        #1;
        // Reset state, before any clock edge.
        check("rst_ready", {15'd0, cmd_ready}, 16'd1);
        check("rst_we", {14'd0, write_enable_A, write_enable_B}, 16'd0);
        check("rst_done", {15'd0, done}, 16'd0);
        check("rst_flags", {14'd0, flag_c, flag_z}, 16'd0);
        check("rst_raddr", {12'd0, read_address_A, read_address_B}, 16'd0);
        check("rst_wdata", {data_input_A, data_input_B}, 16'd0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0; wr_count_clr = 1'b0;
        // Idle with no valid stays idle.
        @(posedge CLK); #1;
        check("idle_hold", {15'd0, cmd_ready}, 16'd1);

        // ADD r2 = r0 + r1.
        preload();
        run_cmd(3'd1, 2'd2, 2'd0, 2'd1, 8'h00, s);
        check("add_read_ready", {15'd0, s.rd_ready}, 16'd0);
        check("add_read_addr", {12'd0, s.ra, s.rb}, {12'd0, 2'd0, 2'd1});
        check("add_done_seq", {13'd0, s.rd_done, s.w_done, s.post_done}, 16'b010);
        check("add_we", {14'd0, s.we_a, s.we_b}, 16'b10);
        check("add_addr", {14'd0, s.wa}, 16'd2);
        check("add_data", {8'd0, s.da}, 16'h05);
        check("add_flags", {14'd0, flag_c, flag_z}, 16'b10);
        check("add_mem", {8'd0, mem[2]}, 16'h05);
        check("add_raddr_hold", {12'd0, read_address_A, read_address_B}, 16'b0001);

        // SUB r3 = r0 - r0, then r0 - r1.
        run_cmd(3'd2, 2'd3, 2'd0, 2'd0, 8'h00, s);
        check("sub0_data", {8'd0, s.da}, 16'h00);
        check("sub0_flags", {14'd0, flag_c, flag_z}, 16'b01);
        run_cmd(3'd2, 2'd3, 2'd0, 2'd1, 8'h00, s);
        check("sub1_data", {8'd0, s.da}, 16'h1B);
        check("sub1_flags", {14'd0, flag_c, flag_z}, 16'b10);

        // SWAP r0<->r1, then same-address SWAP r2.
        run_cmd(3'd7, 2'd0, 2'd0, 2'd1, 8'h00, s);
        check("swap_we", {14'd0, s.we_a, s.we_b}, 16'b11);
        check("swap_portA", {6'd0, s.wa, s.da}, {6'd0, 2'd0, 8'hF5});
        check("swap_portB", {6'd0, s.wb, s.db}, {6'd0, 2'd1, 8'h10});
        check("swap_mem", {mem[0], mem[1]}, 16'hF510);
        check("swap_flags", {14'd0, flag_c, flag_z}, 16'b00);
        run_cmd(3'd7, 2'd0, 2'd2, 2'd2, 8'h00, s);
        check("swap_same_we", {14'd0, s.we_a, s.we_b}, 16'b10);
        check("swap_same_mem", {8'd0, mem[2]}, 16'h05);

        // Back-to-back LDI with cmd_valid held for 9 cycles.
        wr_count_clr = 1'b1;
        @(posedge CLK); #1;
        wr_count_clr = 1'b0;
        cmd_op = 3'd6; cmd_dst = 2'd3; cmd_src_a = 2'd0; cmd_src_b = 2'd0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cmd_imm = 8'(i / 3 + 1);
            check("b2b_ready", {15'd0, cmd_ready}, {15'd0, (i % 3 == 0)});
            if (i % 3 == 2) begin
                check("b2b_wdata", {7'd0, write_enable_A, data_input_A}, {7'd0, 1'b1, 8'(i / 3 + 1)});
            end
            @(posedge CLK); #1;
        end
        cmd_valid = 1'b0;
        check("b2b_writes", 16'(wr_count), 16'd3);
        check("b2b_last", {8'd0, mem[3]}, 16'h03);

        // RST in WRITE aborts an LDI 0xAA to r1.
        cmd_op = 3'd6; cmd_dst = 2'd1; cmd_imm = 8'hAA; cmd_valid = 1'b1;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        @(posedge CLK); #1;
        check("abort_pre_we", {15'd0, write_enable_A}, 16'd1);
        RST = 1'b1;
        #1;
        check("abort_we", {14'd0, write_enable_A, write_enable_B}, 16'd0);
        check("abort_ready", {15'd0, cmd_ready}, 16'd1);
        check("abort_flags", {14'd0, flag_c, flag_z}, 16'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        check("abort_mem", {8'd0, mem[1]}, 16'h10);
        // First accept right after reset release.
        run_cmd(3'd6, 2'd1, 2'd0, 2'd0, 8'h5A, s);
        check("post_rst_accept", {7'd0, s.we_a, s.da}, {7'd0, 1'b1, 8'h5A});

        // Random run against the reference model.
        for (int i = 0; i < 4; i++) ref_mem[i] = mem[i];
        ref_c = flag_c; ref_z = flag_z;
        for (int n = 0; n < 1000; n++) begin
            logic [2:0] op;
            logic [1:0] d, a, b;
            logic [7:0] im;
            op = 3'($urandom_range(7, 0));
            d  = 2'($urandom_range(3, 0));
            a  = 2'($urandom_range(3, 0));
            b  = 2'($urandom_range(3, 0));
            im = 8'($urandom_range(255, 0));
            run_cmd(op, d, a, b, im, s);
            ref_apply(op, d, a, b, im);
            check("rnd_mem", {mem[0], mem[1]}, {ref_mem[0], ref_mem[1]});
            check("rnd_mem_hi", {mem[2], mem[3]}, {ref_mem[2], ref_mem[3]});
            check("rnd_flags", {14'd0, flag_c, flag_z}, {14'd0, ref_c, ref_z});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
